pc_seq_ctrl: RTL and testbench

- Fetch-stage next-PC controller for the 5-stage MIPS pipeline.
- Owns the PC register and chooses each cycle between sequential PC+4, a branch target and a jump target.
- Obeys hazard-unit stalls and the instruction-memory ready handshake, and generates the IF/ID flush.
- Buffers a redirect that arrives while fetch cannot advance, so no branch or jump is ever lost.

---
 rtl/pc_seq_ctrl.sv | 113 +++++++++++
 tb/tb_pc_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Fetch-stage next-PC controller: owns the PC, selects seq/branch/jump,
// honours stall and imem handshake, buffers redirects that cannot apply yet.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             branch,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  output logic             if_req,
  output logic             if_id_flush,
  output logic [1:0]       pc_sel,
  output logic             redirect_pend,
  output logic             conflict,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } state_t;

  state_t           state;
  logic [31:0]      pend_pc;
  logic             pend_mis;
  logic             advance;
  logic             redir;
  logic [31:0]      tgt;
  logic [31:0]      tgt_al;
  logic             run_redir;
  logic             run_apply;
  logic             pend_apply;
  logic [CNT_W-1:0] cnt_inc;

  assign if_req     = ~rst & (state != BOOT);
  assign advance    = if_req & imem_ready & ~stall;
  assign redir      = jump | branch;
  assign tgt        = jump ? jump_target : branch_target;
  assign tgt_al     = {tgt[31:2], 2'b00};
  assign npc        = pc + 32'd4;

  assign run_redir  = ~rst & (state == RUN) & redir;
  assign run_apply  = run_redir & advance;
  assign pend_apply = (state == PEND) & advance;

  assign if_id_flush   = run_apply | pend_apply;
  assign redirect_pend = ~rst & (state == PEND);
  assign conflict      = run_redir & jump & branch;
  assign misalign      = (run_apply & (tgt[1:0] != 2'b00))
                       | (pend_apply & pend_mis);

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (redirect_cnt == {CNT_W{1'b1}})
                 ? redirect_cnt
                 : redirect_cnt + CNT_W'(1);

  always_comb begin
    pc_sel = 2'b00;
    unique case (1'b1)
      pend_apply:         pc_sel = 2'b11;
      run_apply & jump:   pc_sel = 2'b10;
      run_apply & ~jump:  pc_sel = 2'b01;
      default:            pc_sel = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= BOOT;
      pend_pc      <= '0;
      pend_mis     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (advance) begin
            if (redir) begin
              pc           <= tgt_al;
              redirect_cnt <= cnt_inc;
            end else begin
              pc <= npc;
            end
          end else if (redir) begin
            pend_pc  <= tgt_al;
            pend_mis <= tgt[1:0] != 2'b00;
            state    <= PEND;
          end
        end
        // The stalled ID stage re-presents its redirect; ignore it here.
        PEND: begin
          if (advance) begin
            pc           <= pend_pc;
            redirect_cnt <= cnt_inc;
            state        <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: stimulus pushes model expectations,
// a monitor pops and compares each cycle's observed outputs.
module tb_pc_seq_ctrl;

  localparam int          CW   = 4;
  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, stall, imem_ready, jump, branch;
  logic [31:0]   jump_target, branch_target;
  logic [31:0]   pc, npc;
  logic          if_req, if_id_flush, redirect_pend;
  logic          conflict, misalign;
  logic [1:0]    pc_sel;
  logic [CW-1:0] redirect_cnt;

  pc_seq_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_target(branch_target),
    .pc(pc), .npc(npc), .if_req(if_req), .if_id_flush(if_id_flush),
    .pc_sel(pc_sel), .redirect_pend(redirect_pend),
    .conflict(conflict), .misalign(misalign),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_pc;
    logic [31:0] pc;
    logic        req;
    logic        flush;
    logic [1:0]  sel;
    logic        pend;
    logic        conf;
    logic        mis;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: fetch address, boot flag, queue of waiting redirects.
  logic [31:0] m_pc;
  bit          m_valid = 0;
  bit          m_boot  = 0;
  logic [31:0] m_pend_q[$];
  bit          m_pend_mis;
  int          m_cnt   = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic bump();
    if (m_cnt < CMAX) m_cnt++;
  endtask

  task automatic cyc(input bit r, input bit s, input bit rd,
                     input bit j, input logic [31:0] jt,
                     input bit b, input logic [31:0] bt);
    exp_t e;
    bit adv;
    logic [31:0] t;
    @(posedge clk);
    #1;
    rst = r; stall = s; imem_ready = rd;
    jump = j; jump_target = jt; branch = b; branch_target = bt;
    e = '{chk_pc: m_valid, pc: m_pc, req: 0, flush: 0, sel: 2'b00,
          pend: 0, conf: 0, mis: 0, cnt: CW'(m_cnt)};
    if (r) begin
      m_pc = RPC; m_valid = 1; m_boot = 1; m_cnt = 0;
      m_pend_q.delete();
    end else if (m_boot) begin
      m_boot = 0;
    end else begin
      e.req = 1;
      adv = rd && !s;
      if (m_pend_q.size() != 0) begin
        e.pend = 1;
        if (adv) begin
          e.flush = 1; e.sel = 2'b11; e.mis = m_pend_mis;
          m_pc = m_pend_q.pop_front();
          bump();
        end
      end else begin
        e.conf = j && b;
        t = j ? jt : bt;
        if (adv && (j || b)) begin
          e.flush = 1;
          e.sel = j ? 2'b10 : 2'b01;
          e.mis = t[1:0] != 2'b00;
          m_pc = t & ~32'd3;
          bump();
        end else if (adv) begin
          m_pc = m_pc + 32'd4;
        end else if (j || b) begin
          m_pend_q.push_back(t & ~32'd3);
          m_pend_mis = t[1:0] != 2'b00;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic go(input bit j, input logic [31:0] jt,
                    input bit b, input logic [31:0] bt);
    cyc(0, 0, 1, j, jt, b, bt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_pc) begin
          chk("pc", pc, e.pc);
          chk("npc", npc, e.pc + 32'd4);
          chk("redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
        end
        chk("if_req", 32'(if_req), 32'(e.req));
        chk("if_id_flush", 32'(if_id_flush), 32'(e.flush));
        chk("pc_sel", 32'(pc_sel), 32'(e.sel));
        chk("redirect_pend", 32'(redirect_pend), 32'(e.pend));
        chk("conflict", 32'(conflict), 32'(e.conf));
        chk("misalign", 32'(misalign), 32'(e.mis));
      end
    end
  end

  initial begin : stim
    rst = 1; stall = 0; imem_ready = 0;
    jump = 0; branch = 0; jump_target = 0; branch_target = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    // boot with redirect ignored, then 0x3000..0x3010
    go(1, 32'h0000_7000, 0, 0);
    repeat (4) go(0, 0, 0, 0);
    go(0, 0, 1, 32'h0000_3040);
    repeat (3) cyc(0, 1, 1, 1, 32'h0000_3100, 0, 0);
    go(1, 32'h0000_3100, 0, 0);
    go(0, 0, 0, 0);
    go(1, 32'h0000_3200, 1, 32'h0000_3300);
    go(0, 0, 1, 32'h0000_3046);
    go(0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000_3500, 0, 0);
    cyc(0, 1, 1, 1, 32'h0000_3500, 0, 0);
    cyc(1, 1, 1, 1, 32'h0000_3500, 0, 0);
    repeat (3) go(0, 0, 0, 0);
    // PC wraps past the top of the address space
    go(1, 32'hFFFF_FFFC, 0, 0);
    go(0, 0, 0, 0);
    go(0, 0, 0, 0);
    // saturation: more redirects than the counter can hold
    repeat (CMAX + 4) go(0, 0, 1, 32'h0000_3000);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 499) == 0,
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 99) < 15, $urandom,
          $urandom_range(0, 99) < 20, $urandom);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
